// File: rtl/fa_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fa_multiplier_seq
//  Brief    : Sequential shift-add unsigned multiplier. Forms the full
//             2*WIDTH-bit product of A*B over exactly WIDTH cycles using a
//             single WIDTH-bit adder, with a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fa_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] ResHi,
  output logic             Ovf
);

  // Counter just wide enough to index WIDTH iterations.
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_next;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift {carry, acc, mplier} right.
  // The lower half of acc collects the retired product bits, so after WIDTH
  // steps acc holds the complete product.
  always_comb begin
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    acc_next    = {sum, acc[WIDTH-1:1]};
    mplier_next = {acc[0], mplier[WIDTH-1:1]};
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // Control FSM, datapath registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      Res    <= '0;
      ResHi  <= '0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          count  <= count + 1'b1;
          // Results are published only on the last step so they hold
          // steady across IDLE and the whole of the next operation.
          if (count == LAST) begin
            Res   <= acc_next[WIDTH-1:0];
            ResHi <= acc_next[2*WIDTH-1:WIDTH];
            Ovf   <= |acc_next[2*WIDTH-1:WIDTH];
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fa_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fa_multiplier_seq
//  Brief    : Scoreboard bench for fa_multiplier_seq (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fa_multiplier_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Res;
  logic [W-1:0] ResHi;
  logic         Ovf;

  fa_multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Res   (Res),
    .ResHi (ResHi),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0] held_lo = '0;
  logic [W-1:0] held_hi = '0;
  logic         held_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected results on done, checks latency, and checks that
  // the result outputs hold between completions.
  always @(negedge clk) begin
    if (rst) begin
      held_lo  = '0;
      held_hi  = '0;
      held_ovf = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res",     64'(Res),   64'(e.lo));
        chk("reshi",   64'(ResHi), 64'(e.hi));
        chk("ovf",     64'(Ovf),   64'(e.ovf));
        chk("latency", 64'(cyc - e.acc_cyc), 64'(W));
        chk("busy_in_done", 64'(busy), 64'd0);
        held_lo  = e.lo;
        held_hi  = e.hi;
        held_ovf = e.ovf;
      end
    end else begin
      chk("hold", {Res, ResHi[W-1:1], Ovf}, {held_lo, held_hi[W-1:1], held_ovf});
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic push_exp(input logic [63:0] p);
    exp_t e;
    e.lo      = p[W-1:0];
    e.hi      = p[2*W-1:W];
    e.ovf     = (p[2*W-1:W] != '0);
    e.acc_cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] p);
    wait_idle();
    A = a;
    B = b;
    start = 1'b1;
    push_exp(p);
    @(negedge clk);
    start = 1'b0;
    A = '0;
    B = '0;
  endtask

  // Back-to-back table: operands and hand-computed products.
  logic [W-1:0] va[$];
  logic [W-1:0] vb[$];
  logic [63:0]  vp[$];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_res",   64'(Res),   64'd0);
    chk("rst_reshi", 64'(ResHi), 64'd0);
    chk("rst_ovf",   64'(Ovf),   64'd0);
    rst = 1'b0;

    // Basic, zero operands, all-ones operands
    do_op(32'd4, 32'd2, 64'd8);
    wait_drain();
    do_op(32'd0, 32'd0, 64'd0);
    wait_drain();
    do_op(32'd12345, 32'd0, 64'd0);
    wait_drain();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_drain();

    // start during BUSY must be ignored
    do_op(32'd7, 32'd6, 64'd42);
    repeat (5) @(negedge clk);
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("no_second_done", 64'(q.size()), 64'd0);

    // Asynchronous reset mid-operation
    do_op(32'd1, 32'd1, 64'd1);
    repeat (9) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy",  64'(busy),  64'd0);
    chk("async_res",   64'(Res),   64'd0);
    chk("async_reshi", 64'(ResHi), 64'd0);
    chk("async_ovf",   64'(Ovf),   64'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'd3, 32'd5, 64'd15);
    wait_drain();

    // Back-to-back with start held high
    va = {32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
          32'h1234_5678, 32'd1000,      32'h0000_FFFF, 32'h0001_0001,
          32'h0000_5A5A};
    vb = {32'h0001_0000, 32'h0000_0002, 32'h8000_0000, 32'hDEAD_BEEF,
          32'h0000_0010, 32'd1000,      32'h0000_FFFF, 32'h0001_0001,
          32'h0000_0003};
    vp = {64'h0000_0001_0000_0000, 64'h0000_0001_FFFF_FFFE,
          64'h4000_0000_0000_0000, 64'h0000_0000_DEAD_BEEF,
          64'h0000_0001_2345_6780, 64'h0000_0000_000F_4240,
          64'h0000_0000_FFFE_0001, 64'h0000_0001_0002_0001,
          64'h0000_0000_0001_0F0E};
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      va.push_back(ra);
      vb.push_back(rb);
      vp.push_back(64'(ra) * 64'(rb));
    end

    wait_idle();
    start = 1'b1;
    for (int i = 0; i < va.size(); i++) begin
      if (i != 0) wait_idle();
      A = va[i];
      B = vb[i];
      push_exp(vp[i]);
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
